wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the pipeline core. Accepts one retiring instruction per handshake from the memory stage, waits for load data when needed, aligns and sign/zero-extends it, and drives the register file's write port (`rdAddr`, `rd`, `Load`). Optionally exposes a bypass path that Decode uses to forward the pending write.

## Interface
Parameters:
- `XLEN`, 32: data width of results and register-file write data.
- `NREG`, 32: number of architectural registers; address width is `$clog2(NREG)` = 5.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  memory stage presents an instruction.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `in_rdAddr`  in  5  destination register.
- `in_result`  in  XLEN  ALU result; for loads, the effective address.
- `in_LS`  in  2  00 none, 01 load, 10 store, 11 treated as 00.
- `in_Length`  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other values are illegal.
- `in_regWrite`  in  1  instruction writes `rd`.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  XLEN  raw aligned word from data memory.
- `rdAddr`  out  5  register-file write address.
- `rd`  out  XLEN  register-file write data.
- `Load`  out  1  register-file write enable; one-cycle pulse.
- `misalign`  out  1  one-cycle pulse on a misaligned or illegal load.
- `retire_cnt`  out  32  count of retired instructions.
- `fwd_valid`, `fwd_addr[4:0]`, `fwd_data[XLEN-1:0]`  out  present only with `WB_FWD_EN`.

## Operation
- States: IDLE, WAIT_MEM, WRITE.
- `in_ready = (state==IDLE) || (state==WRITE)`.
- An accepted instruction is captured into the holding registers. The next state is WAIT_MEM if `in_LS==01`, otherwise WRITE.
- WAIT_MEM:
  - Holds until `mem_rvalid`.
  - Extracts the byte or half selected by `in_result[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Captures the extended value and moves to WRITE.
- WRITE:
  - `Load=1` iff `regWrite && rdAddr!=0 && !misalign_flag && LS!=10`.
  - `retire_cnt` increments by 1 and wraps at 2^32.
  - Next state is WAIT_MEM or WRITE if an instruction is accepted in the same cycle, otherwise IDLE.
- Misaligned or illegal cases:
  - LH/LHU with offset bit 0 set, LW with offset ≠ 0, or an illegal `Length` on a load.
  - The instruction still waits for `mem_rvalid`.
  - In WRITE, `misalign=1` and `Load=0`; the instruction still retires.
- `mem_rvalid` outside WAIT_MEM is ignored.
- Writes to x0 are never issued.

## Timing
- Reset values: state IDLE, `Load=0`, `misalign=0`, `rdAddr=0`, `rd=0`, `retire_cnt=0`, `fwd_valid=0`. `in_ready=1` once the state is IDLE.
- Non-load latency: accept at cycle N, `Load` high at N+1.
- Back-to-back non-loads retire at one per cycle.
- Load latency: `Load` is high in the cycle after `mem_rvalid` is sampled. If `mem_rvalid` is already high in the first WAIT_MEM cycle, minimum latency is 2 cycles from accept.
- `rdAddr` and `rd` are registered and valid whenever `Load=1`. They hold their values otherwise.
- Reset asserted in any state, including WAIT_MEM: the pending instruction is dropped, no `Load` is issued, and the counter clears.

## Configuration
- `WB_FWD_EN` defined:
  - `fwd_*` ports exist.
  - `fwd_valid` mirrors `Load`, and `fwd_addr`/`fwd_data` mirror `rdAddr`/`rd`, so Decode can bypass the same-cycle register-file write.
  - Additionally, in WAIT_MEM, `fwd_valid=0` and `fwd_addr` carries the pending load destination for hazard stalls.
- `WB_FWD_EN` undefined: the ports and all related logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package `core_pkg`:
  - `ls_e` (NONE, LOAD, STORE).
  - `len_e` (LB, LH, LW, LBU, LHU).
  - `XLEN`, `NREG`.
  - The state enum `wb_state_e`.
- Sub-module `load_align`: combinational extraction and extension from (`mem_rdata`, offset, `Length`) to (data, misalign).

## Test plan
- ALU op with `rdAddr=5`, `result=0x1234` accepted at cycle 10 -> `Load=1`, `rdAddr=5`, `rd=0x1234` at cycle 11, `retire_cnt=1`.
- LB, offset 2, `mem_rdata=0x00800000`, `mem_rvalid` 3 cycles later -> `rd=0xFFFFFF80`, `Load` 1 cycle after `rvalid`. Same case with LBU -> `rd=0x00000080`.
- LW with offset 2 -> `misalign=1`, `Load=0`, `retire_cnt` increments.
- Four back-to-back ALU ops to x1..x4 -> four consecutive `Load` pulses; a write with `rdAddr=0` -> `Load=0`.
- Store, then `rst` pulsed during WAIT_MEM of a following load -> no `Load`, `retire_cnt=0`, state IDLE, a late `mem_rvalid` ignored.
- With `WB_FWD_EN`: LH to x7 pending -> `fwd_addr=7`, `fwd_valid=0` in WAIT_MEM; then `fwd_valid=1` together with `Load`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: load/store kind, load length encodings, writeback FSM states.
package core_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        LOAD  = 2'b01,
        STORE = 2'b10
    } ls_e;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } len_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE
    } wb_state_e;

    // Encoding 11 is reserved and behaves like a plain ALU op.
    function automatic ls_e decode_ls(input logic [1:0] ls);
        return (ls == 2'b11) ? NONE : ls_e'(ls);
    endfunction
endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: picks the addressed byte/half out of a memory word and extends it.
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      length,
    output logic [XLEN-1:0] data,
    output logic            misalign
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = mem_rdata[{offset, 3'b000} +: 8];
    assign w_half = mem_rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (length)
            LB:  data = {{(XLEN-8){w_byte[7]}}, w_byte};
            LBU: data = {{(XLEN-8){1'b0}}, w_byte};
            LH: begin
                data     = {{(XLEN-16){w_half[15]}}, w_half};
                misalign = offset[0];
            end
            LHU: begin
                data     = {{(XLEN-16){1'b0}}, w_half};
                misalign = offset[0];
            end
            LW: begin
                data     = mem_rdata;
                misalign = (offset != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: waits for load data, aligns it and drives the regfile write port.
// Optional WB_FWD_EN adds a bypass port for Decode.
module wb_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NREG)-1:0]  in_rdAddr,
    input  logic [XLEN-1:0]          in_result,
    input  logic [1:0]               in_LS,
    input  logic [2:0]               in_Length,
    input  logic                     in_regWrite,
    input  logic                     mem_rvalid,
    input  logic [XLEN-1:0]          mem_rdata,
    output logic [$clog2(NREG)-1:0]  rdAddr,
    output logic [XLEN-1:0]          rd,
    output logic                     Load,
    output logic                     misalign,
    output logic [31:0]              retire_cnt
`ifdef WB_FWD_EN
    ,
    output logic                     fwd_valid,
    output logic [$clog2(NREG)-1:0]  fwd_addr,
    output logic [XLEN-1:0]          fwd_data
`endif
);
    localparam int AW = $clog2(NREG);

    wb_state_e       r_state;
    logic [AW-1:0]   r_h_addr;
    logic [1:0]      r_h_off;
    logic [2:0]      r_h_len;
    logic            r_h_we;

    logic            w_accept;
    ls_e             w_in_ls;
    logic [XLEN-1:0] w_al_data;
    logic            w_al_mis;
    logic            w_ret;
    logic            w_ret_we;
    logic            w_ret_mis;
    logic [AW-1:0]   w_ret_addr;
    logic [XLEN-1:0] w_ret_data;

    assign in_ready = (r_state == IDLE) || (r_state == WRITE);
    assign w_accept = in_valid && in_ready;
    assign w_in_ls  = decode_ls(in_LS);

    load_align #(.XLEN(XLEN)) u_align (
        .mem_rdata (mem_rdata),
        .offset    (r_h_off),
        .length    (r_h_len),
        .data      (w_al_data),
        .misalign  (w_al_mis)
    );

    // Retirement happens on the edge that enters WRITE: either a non-load
    // accepted now, or the pending load seeing its data.
    always_comb begin
        w_ret      = 1'b0;
        w_ret_we   = 1'b0;
        w_ret_mis  = 1'b0;
        w_ret_addr = in_rdAddr;
        w_ret_data = in_result;
        if (r_state == WAIT_MEM) begin
            w_ret      = mem_rvalid;
            w_ret_addr = r_h_addr;
            w_ret_data = w_al_data;
            w_ret_mis  = w_al_mis;
            w_ret_we   = r_h_we && !w_al_mis;
        end else begin
            w_ret    = w_accept && (w_in_ls != LOAD);
            w_ret_we = in_regWrite && (w_in_ls != STORE);
        end
        w_ret_we = w_ret && w_ret_we && (w_ret_addr != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_h_addr   <= '0;
            r_h_off    <= '0;
            r_h_len    <= '0;
            r_h_we     <= 1'b0;
            Load       <= 1'b0;
            misalign   <= 1'b0;
            rdAddr     <= '0;
            rd         <= '0;
            retire_cnt <= '0;
        end else begin
            Load     <= w_ret_we;
            misalign <= w_ret && w_ret_mis;
            if (w_ret)
                retire_cnt <= retire_cnt + 32'd1;
            if (w_ret_we) begin
                rdAddr <= w_ret_addr;
                rd     <= w_ret_data;
            end
            if (w_accept) begin
                r_h_addr <= in_rdAddr;
                r_h_off  <= in_result[1:0];
                r_h_len  <= in_Length;
                r_h_we   <= in_regWrite;
            end
            case (r_state)
                IDLE, WRITE: begin
                    if (w_accept)
                        r_state <= (w_in_ls == LOAD) ? WAIT_MEM : WRITE;
                    else
                        r_state <= IDLE;
                end
                WAIT_MEM: begin
                    if (mem_rvalid)
                        r_state <= WRITE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef WB_FWD_EN
    // While a load is outstanding Decode sees its destination so it can stall.
    assign fwd_valid = Load && (r_state != WAIT_MEM);
    assign fwd_addr  = (r_state == WAIT_MEM) ? r_h_addr : rdAddr;
    assign fwd_data  = rd;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: vector table plus scoreboard of expected regfile writes.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rdAddr;
    logic [31:0] in_result;
    logic [1:0]  in_LS;
    logic [2:0]  in_Length;
    logic        in_regWrite;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rdAddr;
    logic [31:0] rd;
    logic        Load;
    logic        misalign;
    logic [31:0] retire_cnt;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    wb_stage #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rdAddr(in_rdAddr), .in_result(in_result), .in_LS(in_LS),
        .in_Length(in_Length), .in_regWrite(in_regWrite),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rdAddr(rdAddr), .rd(rd), .Load(Load), .misalign(misalign),
        .retire_cnt(retire_cnt)
`ifdef WB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] result;
        logic [1:0]  ls;
        logic [2:0]  len;
        logic        we;
        logic [31:0] rdata;
        int          dly;
        logic        e_load;
        logic        e_mis;
        logic [31:0] e_rd;
    } vec_t;

    typedef struct {
        logic        load;
        logic        mis;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt;
    vec_t        vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic ld, input logic mis, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.load = ld; e.mis = mis; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every Load or misalign pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (Load === 1'b1 || misalign === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: Load=%b misalign=%b rdAddr=%0d, expected no event",
                         Load, misalign, rdAddr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_load", {31'b0, Load}, {31'b0, e.load});
                chk("sb_mis", {31'b0, misalign}, {31'b0, e.mis});
                if (e.load) begin
                    chk("sb_rdAddr", {27'b0, rdAddr}, {27'b0, e.addr});
                    chk("sb_rd", rd, e.data);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        chk("ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_rdAddr = v.addr; in_result = v.result; in_LS = v.ls;
        in_Length = v.len; in_regWrite = v.we; mem_rdata = v.rdata;
        if (v.e_load || v.e_mis) push_exp(v.e_load, v.e_mis, v.addr, v.e_rd);
        exp_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (v.ls == 2'b01) begin
            for (int k = 0; k < v.dly; k++) begin
                chk("wait_noload", {31'b0, Load | misalign}, 32'd0);
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b1;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
        end
        chk("lat_load", {31'b0, Load}, {31'b0, v.e_load});
        chk("lat_mis", {31'b0, misalign}, {31'b0, v.e_mis});
        chk("retire_cnt", retire_cnt, exp_cnt);
        @(posedge clk); #1;
        chk("pulse_end", {31'b0, Load | misalign}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        addr   result        ls     len     we    rdata          dly ld  mis  rd
        vt[0]  = '{5'd5,  32'h0000_1234, 2'b00, 3'd0, 1'b1, 32'h0,         0, 1'b1, 1'b0, 32'h0000_1234};
        vt[1]  = '{5'd6,  32'h0000_1002, 2'b01, 3'd0, 1'b1, 32'h0080_0000, 3, 1'b1, 1'b0, 32'hFFFF_FF80};
        vt[2]  = '{5'd6,  32'h0000_1002, 2'b01, 3'd4, 1'b1, 32'h0080_0000, 3, 1'b1, 1'b0, 32'h0000_0080};
        vt[3]  = '{5'd7,  32'h0000_2002, 2'b01, 3'd1, 1'b1, 32'h8001_0000, 1, 1'b1, 1'b0, 32'hFFFF_8001};
        vt[4]  = '{5'd8,  32'h0000_2000, 2'b01, 3'd5, 1'b1, 32'h1234_F00D, 0, 1'b1, 1'b0, 32'h0000_F00D};
        vt[5]  = '{5'd9,  32'h0000_3000, 2'b01, 3'd2, 1'b1, 32'hDEAD_BEEF, 2, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vt[6]  = '{5'd10, 32'h0000_3002, 2'b01, 3'd2, 1'b1, 32'h1111_2222, 1, 1'b0, 1'b1, 32'h0};
        vt[7]  = '{5'd11, 32'h0000_3001, 2'b01, 3'd1, 1'b1, 32'h3333_4444, 0, 1'b0, 1'b1, 32'h0};
        vt[8]  = '{5'd11, 32'h0000_3000, 2'b01, 3'd3, 1'b1, 32'h5555_6666, 0, 1'b0, 1'b1, 32'h0};
        vt[9]  = '{5'd12, 32'h0000_AAAA, 2'b00, 3'd0, 1'b0, 32'h0,         0, 1'b0, 1'b0, 32'h0};
        vt[10] = '{5'd0,  32'h0000_FFFF, 2'b00, 3'd0, 1'b1, 32'h0,         0, 1'b0, 1'b0, 32'h0};
        vt[11] = '{5'd3,  32'h0000_0040, 2'b10, 3'd2, 1'b1, 32'h0,         0, 1'b0, 1'b0, 32'h0};
        vt[12] = '{5'd12, 32'h0000_CAFE, 2'b11, 3'd0, 1'b1, 32'h0,         0, 1'b1, 1'b0, 32'h0000_CAFE};
        vt[13] = '{5'd13, 32'h0000_4003, 2'b01, 3'd0, 1'b1, 32'h7F00_0000, 1, 1'b1, 1'b0, 32'h0000_007F};
        vt[14] = '{5'd0,  32'h0000_4000, 2'b01, 3'd2, 1'b1, 32'h0000_0055, 0, 1'b0, 1'b0, 32'h0};
        vt[15] = '{5'd14, 32'h0000_4001, 2'b01, 3'd5, 1'b1, 32'h0000_0000, 0, 1'b0, 1'b1, 32'h0};
        vt[16] = '{5'd15, 32'h0000_4001, 2'b01, 3'd4, 1'b1, 32'h0000_FF00, 2, 1'b1, 1'b0, 32'h0000_00FF};

        rst = 1'b1; in_valid = 1'b0; in_rdAddr = '0; in_result = '0; in_LS = '0;
        in_Length = '0; in_regWrite = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        exp_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_Load", {31'b0, Load}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_rdAddr", {27'b0, rdAddr}, 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_retire_cnt", retire_cnt, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) run_vec(vt[i]);

        // Back-to-back ALU ops to x1..x4: one Load per cycle.
        @(posedge clk); #1;
        in_valid = 1'b1; in_LS = 2'b00; in_regWrite = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_rdAddr = 5'(i);
            in_result = 32'h100 + 32'(i);
            push_exp(1'b1, 1'b0, 5'(i), 32'h100 + 32'(i));
            exp_cnt++;
            @(posedge clk); #1;
            chk("b2b_ready", {31'b0, in_ready}, 32'd1);
            chk("b2b_Load", {31'b0, Load}, 32'd1);
            chk("b2b_rdAddr", {27'b0, rdAddr}, 32'(i));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_done", {31'b0, Load}, 32'd0);
        chk("b2b_cnt", retire_cnt, exp_cnt);

        // Store, then a load accepted in WRITE and reset while it waits.
        in_valid = 1'b1; in_LS = 2'b10; in_rdAddr = 5'd20; in_result = 32'h80; in_regWrite = 1'b1;
        @(posedge clk); #1;
        in_LS = 2'b01; in_Length = 3'd2; in_rdAddr = 5'd21; in_result = 32'h84;
        chk("st_ready_write", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ld_waiting_ready", {31'b0, in_ready}, 32'd0);
        chk("st_retired_cnt", retire_cnt, exp_cnt + 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = '0;
        chk("rstw_cnt", retire_cnt, 32'd0);
        chk("rstw_ready", {31'b0, in_ready}, 32'd1);
        chk("rstw_Load", {31'b0, Load}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hABCD_0123;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("late_rvalid_Load", {31'b0, Load | misalign}, 32'd0);
        chk("late_rvalid_cnt", retire_cnt, 32'd0);
        chk("late_rvalid_ready", {31'b0, in_ready}, 32'd1);

`ifdef WB_FWD_EN
        // Pending LH to x7 is visible on the bypass address before it writes.
        @(posedge clk); #1;
        in_valid = 1'b1; in_LS = 2'b01; in_Length = 3'd1; in_rdAddr = 5'd7;
        in_result = 32'h200; in_regWrite = 1'b1; mem_rdata = 32'h0000_8001;
        push_exp(1'b1, 1'b0, 5'd7, 32'hFFFF_8001);
        exp_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("fwd_wait_valid", {31'b0, fwd_valid}, 32'd0);
        chk("fwd_wait_addr", {27'b0, fwd_addr}, 32'd7);
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("fwd_valid", {31'b0, fwd_valid}, 32'd1);
        chk("fwd_Load", {31'b0, Load}, 32'd1);
        chk("fwd_addr", {27'b0, fwd_addr}, 32'd7);
        chk("fwd_data", fwd_data, 32'hFFFF_8001);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("final_cnt", retire_cnt, exp_cnt);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
